// File: rtl/byte_serial_add_ctrl_pkg.sv
// Shared constants for the byte-serial add controller: limb width and FSM encoding.
package byte_serial_add_ctrl_pkg;

  localparam int LIMB_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/byte_serial_add_ctrl_if.sv
// Operand intake / result delivery bundle for byte_serial_add_ctrl.
// SERIAL_ADDSUB_EN adds the sub request bit and the ovf result bit.
interface byte_serial_add_ctrl_if #(
  parameter int NBYTES = 4
);
  import byte_serial_add_ctrl_pkg::*;

  localparam int W = LIMB_W * NBYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         co;
  logic         busy;
`ifdef SERIAL_ADDSUB_EN
  logic         sub;
  logic         ovf;
`endif

  modport master (
    output in_valid, a, b, ci, out_ready,
`ifdef SERIAL_ADDSUB_EN
    output sub,
    input  ovf,
`endif
    input  in_ready, out_valid, sum, co, busy
  );

  modport slave (
    input  in_valid, a, b, ci, out_ready,
`ifdef SERIAL_ADDSUB_EN
    input  sub,
    output ovf,
`endif
    output in_ready, out_valid, sum, co, busy
  );

endinterface

// File: rtl/byte_serial_add_ctrl_add8_slice.sv
// Combinational 8-bit full adder slice shared by every limb of the serial add.
module add8_slice (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       ci_i,
  output logic [7:0] y_o,
  output logic       co_o
);

  assign {co_o, y_o} = {1'b0, a_i} + {1'b0, b_i} + {8'd0, ci_i};

endmodule

// File: rtl/byte_serial_add_ctrl.sv
// Adds two NBYTES-wide operands one byte per clock through a single add8_slice.
// Optional macro SERIAL_ADDSUB_EN enables subtract requests and signed overflow.
module byte_serial_add_ctrl
  import byte_serial_add_ctrl_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  byte_serial_add_ctrl_if.slave bus
);

  localparam int W  = LIMB_W * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

  state_t       state_q, state_d;
  logic [W-1:0] opA_q, opA_d;
  logic [W-1:0] opB_q, opB_d;
  logic [W-1:0] sum_q, sum_d;
  logic         co_q, co_d;
  logic         carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic         subEff;
  logic [7:0]   sliceA;
  logic [7:0]   sliceB;
  logic [7:0]   sliceY;
  logic         sliceCo;

`ifdef SERIAL_ADDSUB_EN
  logic sub_q, sub_d;
  logic ovf_q, ovf_d;
  logic sliceOvf;

  assign subEff   = sub_q;
  assign sliceOvf = (sliceA[7] == sliceB[7]) && (sliceY[7] != sliceA[7]);
  assign bus.ovf  = ovf_q;
`else
  assign subEff = 1'b0;
`endif

  // Subtraction is a + ~b + 1, so only the B byte and the initial carry change.
  assign sliceA = opA_q[7:0];
  assign sliceB = subEff ? ~opB_q[7:0] : opB_q[7:0];

  add8_slice u_slice (
    .a_i  (sliceA),
    .b_i  (sliceB),
    .ci_i (carry_q),
    .y_o  (sliceY),
    .co_o (sliceCo)
  );

  always_comb begin
    state_d = state_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    sum_d   = sum_q;
    co_d    = co_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDSUB_EN
    sub_d   = sub_q;
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          opA_d   = bus.a;
          opB_d   = bus.b;
          cnt_d   = '0;
`ifdef SERIAL_ADDSUB_EN
          sub_d   = bus.sub;
          carry_d = bus.sub ? 1'b1 : bus.ci;
`else
          carry_d = bus.ci;
`endif
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Result bytes enter from the top so byte 0 lands at the bottom after NBYTES shifts.
        opA_d   = opA_q >> LIMB_W;
        opB_d   = opB_q >> LIMB_W;
        sum_d   = {sliceY, sum_q[W-1:LIMB_W]};
        carry_d = sliceCo;
        if (cnt_q == LAST_IDX) begin
          co_d    = sliceCo;
          cnt_d   = '0;
`ifdef SERIAL_ADDSUB_EN
          ovf_d   = sliceOvf;
`endif
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      opA_q   <= '0;
      opB_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDSUB_EN
      sub_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDSUB_EN
      sub_q   <= sub_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.sum       = sum_q;
  assign bus.co        = co_q;

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// Directed self-checking bench for byte_serial_add_ctrl (NBYTES=4).
// Exercises subtract/overflow cases when built with SERIAL_ADDSUB_EN.
module tb_byte_serial_add_ctrl;

  logic clk;
  logic rst_n;
  int   assertCount;
  int   failCount;
  int   cycles;
  logic sawValid;

  byte_serial_add_ctrl_if #(.NBYTES(4)) bus ();

  byte_serial_add_ctrl #(.NBYTES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents one request for a single cycle; the edge inside this task is the accept edge.
  task automatic applyStimulus(input logic [31:0] aVal, input logic [31:0] bVal,
                               input logic ciVal, input logic subVal);
    bus.a        = aVal;
    bus.b        = bVal;
    bus.ci       = ciVal;
`ifdef SERIAL_ADDSUB_EN
    bus.sub      = subVal;
`else
    if (subVal) $display("[TB] sub request ignored in add-only build");
`endif
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic waitResult(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.out_valid !== 1'b1 && n < 20);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    assertCount   = 0;
    failCount     = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.ci        = 1'b0;
    bus.out_ready = 1'b0;
`ifdef SERIAL_ADDSUB_EN
    bus.sub       = 1'b0;
`endif
    tick();
    tick();
    $display("[TB] reset state");
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_sum", 64'(bus.sum), 64'd0);
    checkOutput("rst_co", 64'(bus.co), 64'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] carry ripple through every byte");
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    checkOutput("t1_busy_run", 64'(bus.busy), 64'd1);
    checkOutput("t1_in_ready_run", 64'(bus.in_ready), 64'd0);
    waitResult(cycles);
    checkOutput("t1_latency", 64'(cycles), 64'd4);
    checkOutput("t1_sum", 64'(bus.sum), 64'h0000_0000);
    checkOutput("t1_co", 64'(bus.co), 64'd1);
    drain();
    checkOutput("t1_in_ready_after", 64'(bus.in_ready), 64'd1);
    checkOutput("t1_out_valid_after", 64'(bus.out_valid), 64'd0);

    $display("[TB] carry-in and backpressure");
    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
    waitResult(cycles);
    checkOutput("t2_latency", 64'(cycles), 64'd4);
    checkOutput("t2_sum", 64'(bus.sum), 64'h2345_678A);
    checkOutput("t2_co", 64'(bus.co), 64'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("bp_out_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("bp_sum", 64'(bus.sum), 64'h2345_678A);
      checkOutput("bp_co", 64'(bus.co), 64'd0);
      checkOutput("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    drain();
    checkOutput("bp_in_ready_after", 64'(bus.in_ready), 64'd1);
    checkOutput("bp_out_valid_after", 64'(bus.out_valid), 64'd0);
    checkOutput("bp_busy_after", 64'(bus.busy), 64'd0);

    $display("[TB] request ignored while busy");
    applyStimulus(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
    bus.a        = 32'hDEAD_BEEF;
    bus.b        = 32'h0000_0000;
    bus.ci       = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    checkOutput("t3_in_ready_run", 64'(bus.in_ready), 64'd0);
    waitResult(cycles);
    checkOutput("t3_latency", 64'(cycles), 64'd3);
    checkOutput("t3_sum", 64'(bus.sum), 64'h0000_0003);
    checkOutput("t3_co", 64'(bus.co), 64'd0);
    tick();
    checkOutput("t3_still_done", 64'(bus.out_valid), 64'd1);
    checkOutput("t3_sum_held", 64'(bus.sum), 64'h0000_0003);
    drain();
    checkOutput("t3_idle_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    checkOutput("t3_pending_accepted", 64'(bus.busy), 64'd1);
    waitResult(cycles);
    checkOutput("t3b_latency", 64'(cycles), 64'd4);
    checkOutput("t3b_sum", 64'(bus.sum), 64'hDEAD_BEEF);
    checkOutput("t3b_co", 64'(bus.co), 64'd0);
    drain();

    $display("[TB] reset mid-run");
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("mr_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("mr_sum", 64'(bus.sum), 64'd0);
    checkOutput("mr_co", 64'(bus.co), 64'd0);
    checkOutput("mr_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("mr_busy", 64'(bus.busy), 64'd0);
    sawValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_valid !== 1'b0) sawValid = 1'b1;
    end
    checkOutput("mr_no_result", 64'(sawValid), 64'd0);

`ifdef SERIAL_ADDSUB_EN
    $display("[TB] subtract and overflow");
    applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    bus.sub = 1'b0;
    waitResult(cycles);
    checkOutput("s1_sum", 64'(bus.sum), 64'hFFFF_FFFE);
    checkOutput("s1_co", 64'(bus.co), 64'd0);
    checkOutput("s1_ovf", 64'(bus.ovf), 64'd0);
    drain();
    applyStimulus(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    bus.sub = 1'b0;
    waitResult(cycles);
    checkOutput("s2_sum", 64'(bus.sum), 64'h8000_0000);
    checkOutput("s2_co", 64'(bus.co), 64'd0);
    checkOutput("s2_ovf", 64'(bus.ovf), 64'd1);
    drain();
    applyStimulus(32'h0000_0009, 32'h0000_0003, 1'b0, 1'b1);
    bus.sub = 1'b0;
    waitResult(cycles);
    checkOutput("s3_sum", 64'(bus.sum), 64'h0000_0006);
    checkOutput("s3_co", 64'(bus.co), 64'd1);
    checkOutput("s3_ovf", 64'(bus.ovf), 64'd0);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
